// File: rtl/riscv_pkg.sv
// Shared register-file types: default widths, address/data typedefs and the clear FSM states.
package riscv_pkg;
   localparam int RF_ADD_WIDTH  = 5;
   localparam int RF_DATA_WIDTH = 32;

   typedef logic [RF_ADD_WIDTH-1:0]  reg_addr_t;
   typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

   typedef enum logic {CLEAR, RUN} rf_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, masked by same-cycle writes.
module rf_scoreboard
   import riscv_pkg::*;
#(
   parameter int ADD_WIDTH = RF_ADD_WIDTH,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 2,
   parameter int ZERO_REG  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [NUM_RD*ADD_WIDTH-1:0] add_rs,
   input  logic [NUM_WR*ADD_WIDTH-1:0] add_rd,
   input  logic [NUM_WR-1:0]           wr_en,
   input  logic                        sb_set,
   input  logic [ADD_WIDTH-1:0]        sb_rd,
   output logic [NUM_RD-1:0]           busy_rs
);
   localparam int DEPTH = 1 << ADD_WIDTH;

   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] set_vec;
   logic [DEPTH-1:0] clr_vec;

   // wr_en arrives already qualified by RUN and the zero-register rule
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (en && sb_set && !(ZERO_REG != 0 && sb_rd == '0))
         set_vec[sb_rd] = 1'b1;
      for (int j = 0; j < NUM_WR; j++)
         if (wr_en[j])
            clr_vec[add_rd[j*ADD_WIDTH +: ADD_WIDTH]] = 1'b1;
   end

   // Set beats clear: the issuing instruction is the newer producer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            if (set_vec[r])
               pending[r] <= 1'b1;
            else if (clr_vec[r])
               pending[r] <= 1'b0;
         end
      end
   end

   always_comb begin
      logic [ADD_WIDTH-1:0] a;
      logic                 hit;
      busy_rs = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         a   = add_rs[k*ADD_WIDTH +: ADD_WIDTH];
         hit = 1'b0;
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && add_rd[j*ADD_WIDTH +: ADD_WIDTH] == a)
               hit = 1'b1;
         busy_rs[k] = en && pending[a] && !hit && !(ZERO_REG != 0 && a == '0);
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, pending scoreboard and
// a post-reset clear sequencer that zeroes every entry before ready rises.
module regfile_mp
   import riscv_pkg::*;
#(
   parameter int ADD_WIDTH  = RF_ADD_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_RD*ADD_WIDTH-1:0]  add_rs,
   output logic [NUM_RD*DATA_WIDTH-1:0] data_rs,
   output logic [NUM_RD-1:0]            busy_rs,
   input  logic [NUM_WR*ADD_WIDTH-1:0]  add_rd,
   input  logic [NUM_WR*DATA_WIDTH-1:0] write_data,
   input  logic [NUM_WR-1:0]            regwrite,
   input  logic                         sb_set,
   input  logic [ADD_WIDTH-1:0]         sb_rd,
   output logic                         ready
);
   localparam int DEPTH = 1 << ADD_WIDTH;

   rf_state_t             state;
   logic [ADD_WIDTH:0]    cnt;
   logic [ADD_WIDTH:0]    cnt_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  run;
   logic [NUM_WR-1:0]     wr_eff;

   assign run     = (state == RUN);
   assign cnt_nxt = cnt + (ADD_WIDTH+1)'(1);

   always_comb begin
      wr_eff = '0;
      for (int j = 0; j < NUM_WR; j++)
         wr_eff[j] = run && regwrite[j] &&
                     !(ZERO_REG != 0 && add_rd[j*ADD_WIDTH +: ADD_WIDTH] == '0);
   end

   // The extra counter bit flags the write of the last entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
         ready <= 1'b0;
      end else if (state == CLEAR) begin
         cnt <= cnt_nxt;
         if (cnt_nxt[ADD_WIDTH]) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end
   end

   // Ascending port order lets the highest-indexed writer win
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt[ADD_WIDTH-1:0]] <= '0;
      end else if (rst_n) begin
         for (int j = 0; j < NUM_WR; j++)
            if (wr_eff[j])
               mem[add_rd[j*ADD_WIDTH +: ADD_WIDTH]] <= write_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      logic [ADD_WIDTH-1:0]  a;
      logic [DATA_WIDTH-1:0] d;
      data_rs = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         a = add_rs[k*ADD_WIDTH +: ADD_WIDTH];
         d = mem[a];
         for (int j = 0; j < NUM_WR; j++)
            if (wr_eff[j] && add_rd[j*ADD_WIDTH +: ADD_WIDTH] == a)
               d = write_data[j*DATA_WIDTH +: DATA_WIDTH];
         if (!run || (ZERO_REG != 0 && a == '0))
            d = '0;
         data_rs[k*DATA_WIDTH +: DATA_WIDTH] = d;
      end
   end

   rf_scoreboard #(
      .ADD_WIDTH (ADD_WIDTH),
      .NUM_RD    (NUM_RD),
      .NUM_WR    (NUM_WR),
      .ZERO_REG  (ZERO_REG)
   ) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (run),
      .add_rs  (add_rs),
      .add_rd  (add_rd),
      .wr_en   (wr_eff),
      .sb_set  (sb_set),
      .sb_rd   (sb_rd),
      .busy_rs (busy_rs)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence, bypass, write priority, x0, scoreboard, mid-run reset.
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  add_rs;
   logic [63:0] data_rs;
   logic [1:0]  busy_rs;
   logic [9:0]  add_rd;
   logic [63:0] write_data;
   logic [1:0]  regwrite;
   logic        sb_set;
   logic [4:0]  sb_rd;
   logic        ready;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .add_rs     (add_rs),
      .data_rs    (data_rs),
      .busy_rs    (busy_rs),
      .add_rd     (add_rd),
      .write_data (write_data),
      .regwrite   (regwrite),
      .sb_set     (sb_set),
      .sb_rd      (sb_rd),
      .ready      (ready)
   );

   // Advance to just after the next edge and drop all write/issue strobes
   task automatic next_idle();
      @(posedge clk);
      #1;
      regwrite = 2'b00;
      sb_set   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      tests++;
      if (ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready_low: got %b expected 0", ready);
      end
      rst_n  = 1'b1;
      add_rs = {5'd31, 5'd6};
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         tests++;
         if (ready !== 1'b0) begin
            fails++;
            $display("FAIL clear_ready cycle %0d: got %b expected 0", i, ready);
         end
         tests++;
         if (data_rs !== 64'h0 || busy_rs !== 2'b00) begin
            fails++;
            $display("FAIL clear_reads cycle %0d: got data %h busy %b expected 0/00", i, data_rs, busy_rs);
         end
         @(posedge clk);
      end
      @(negedge clk);
      tests++;
      if (ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_clear: got %b expected 1", ready);
      end
      tests++;
      if (data_rs !== 64'h0) begin
         fails++;
         $display("FAIL x6_x31_after_clear: got %h expected 0", data_rs);
      end
   endtask

   task automatic test_bypass();
      next_idle();
      regwrite         = 2'b01;
      add_rd[4:0]      = 5'd5;
      write_data[31:0] = 32'h0000_00AA;
      add_rs[4:0]      = 5'd5;
      @(negedge clk);
      tests++;
      if (data_rs[31:0] !== 32'hAA) begin
         fails++;
         $display("FAIL bypass_same_cycle: got %h expected 000000aa", data_rs[31:0]);
      end
      next_idle();
      @(negedge clk);
      tests++;
      if (data_rs[31:0] !== 32'hAA) begin
         fails++;
         $display("FAIL bypass_next_cycle: got %h expected 000000aa", data_rs[31:0]);
      end
   endtask

   task automatic test_dual_write();
      next_idle();
      regwrite   = 2'b11;
      add_rd     = {5'd7, 5'd7};
      write_data = {32'h22, 32'h11};
      add_rs     = {5'd7, 5'd7};
      @(negedge clk);
      tests++;
      if (data_rs !== {32'h22, 32'h22}) begin
         fails++;
         $display("FAIL dual_bypass: got %h expected 0000002200000022", data_rs);
      end
      next_idle();
      @(negedge clk);
      tests++;
      if (data_rs[63:32] !== 32'h22) begin
         fails++;
         $display("FAIL dual_stored: got %h expected 00000022", data_rs[63:32]);
      end
   endtask

   task automatic test_zero_reg();
      next_idle();
      regwrite         = 2'b01;
      add_rd[4:0]      = 5'd0;
      write_data[31:0] = 32'hDEAD_BEEF;
      sb_set           = 1'b1;
      sb_rd            = 5'd0;
      add_rs           = {5'd0, 5'd0};
      @(negedge clk);
      tests++;
      if (data_rs !== 64'h0 || busy_rs !== 2'b00) begin
         fails++;
         $display("FAIL x0_same_cycle: got data %h busy %b expected 0/00", data_rs, busy_rs);
      end
      next_idle();
      @(negedge clk);
      tests++;
      if (data_rs !== 64'h0 || busy_rs !== 2'b00) begin
         fails++;
         $display("FAIL x0_after: got data %h busy %b expected 0/00", data_rs, busy_rs);
      end
   endtask

   task automatic test_scoreboard();
      next_idle();
      sb_set = 1'b1;
      sb_rd  = 5'd9;
      add_rs = {5'd9, 5'd9};
      @(negedge clk);
      tests++;
      if (busy_rs !== 2'b00) begin
         fails++;
         $display("FAIL sb_issue_cycle: got %b expected 00", busy_rs);
      end
      next_idle();
      @(negedge clk);
      tests++;
      if (busy_rs !== 2'b11) begin
         fails++;
         $display("FAIL sb_pending: got %b expected 11", busy_rs);
      end
      next_idle();
      regwrite          = 2'b10;
      add_rd[9:5]       = 5'd9;
      write_data[63:32] = 32'h99;
      @(negedge clk);
      tests++;
      if (busy_rs !== 2'b00 || data_rs[31:0] !== 32'h99) begin
         fails++;
         $display("FAIL sb_writeback: got busy %b data %h expected 00/00000099", busy_rs, data_rs[31:0]);
      end
      next_idle();
      @(negedge clk);
      tests++;
      if (busy_rs !== 2'b00 || data_rs[31:0] !== 32'h99) begin
         fails++;
         $display("FAIL sb_after_wb: got busy %b data %h expected 00/00000099", busy_rs, data_rs[31:0]);
      end
      next_idle();
      sb_set           = 1'b1;
      sb_rd            = 5'd9;
      regwrite         = 2'b01;
      add_rd[4:0]      = 5'd9;
      write_data[31:0] = 32'h123;
      @(negedge clk);
      tests++;
      if (busy_rs !== 2'b00 || data_rs[31:0] !== 32'h123) begin
         fails++;
         $display("FAIL sb_set_wb_same: got busy %b data %h expected 00/00000123", busy_rs, data_rs[31:0]);
      end
      next_idle();
      @(negedge clk);
      tests++;
      if (busy_rs !== 2'b11) begin
         fails++;
         $display("FAIL sb_set_wins: got %b expected 11", busy_rs);
      end
   endtask

   task automatic test_back_to_back();
      next_idle();
      regwrite   = 2'b11;
      add_rd     = {5'd11, 5'd10};
      write_data = {32'hB1, 32'hA0};
      next_idle();
      regwrite   = 2'b11;
      add_rd     = {5'd10, 5'd12};
      write_data = {32'hD0, 32'hC2};
      add_rs     = {5'd11, 5'd10};
      @(negedge clk);
      tests++;
      if (data_rs !== {32'hB1, 32'hD0}) begin
         fails++;
         $display("FAIL b2b_bypass: got %h expected 000000b1000000d0", data_rs);
      end
      next_idle();
      add_rs = {5'd10, 5'd12};
      @(negedge clk);
      tests++;
      if (data_rs !== {32'hD0, 32'hC2}) begin
         fails++;
         $display("FAIL b2b_stored: got %h expected 000000d0000000c2", data_rs);
      end
   endtask

   task automatic test_mid_reset();
      next_idle();
      regwrite         = 2'b01;
      add_rd[4:0]      = 5'd3;
      write_data[31:0] = 32'h55;
      sb_set           = 1'b1;
      sb_rd            = 5'd12;
      next_idle();
      add_rs = {5'd12, 5'd3};
      @(negedge clk);
      tests++;
      if (data_rs[31:0] !== 32'h55 || busy_rs !== 2'b10) begin
         fails++;
         $display("FAIL pre_reset: got data %h busy %b expected 00000055/10", data_rs[31:0], busy_rs);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         tests++;
         if (ready !== 1'b0 || data_rs !== 64'h0 || busy_rs !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset_clear cycle %0d: got ready %b data %h busy %b expected 0/0/00",
                     i, ready, data_rs, busy_rs);
         end
         @(posedge clk);
      end
      @(negedge clk);
      tests++;
      if (ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset_ready: got %b expected 1", ready);
      end
      tests++;
      if (data_rs[31:0] !== 32'h0 || busy_rs !== 2'b00) begin
         fails++;
         $display("FAIL mid_reset_state: got x3 %h busy %b expected 0/00", data_rs[31:0], busy_rs);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      add_rs     = '0;
      add_rd     = '0;
      write_data = '0;
      regwrite   = 2'b00;
      sb_set     = 1'b0;
      sb_rd      = '0;
      test_reset();
      test_bypass();
      test_dual_write();
      test_zero_reg();
      test_scoreboard();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
